// File: rtl/misc_v_pkg.sv
// Shared MISC-V datapath definitions: the machine word width and word type
// used by every storage element in the datapath.
package misc_v_pkg;

  localparam int WORD_WIDTH = 16;

  typedef logic [WORD_WIDTH-1:0] word_t;

endpackage : misc_v_pkg

// File: rtl/register_16.sv
// General-purpose enabled storage register for the MISC-V datapath (PC, IR,
// A/B/ALUOut latches, register-file entries), cleared by an async active-low reset.
module register_16
  import misc_v_pkg::*;
#(
  parameter int               WIDTH       = WORD_WIDTH,
  parameter logic [WIDTH-1:0] RESET_VALUE = '0
) (
  input  logic             CLK,
  input  logic             reset,
  input  logic [WIDTH-1:0] reg_input,
  input  logic             reg_write,
  output logic [WIDTH-1:0] reg_output
);

  logic [WIDTH-1:0] data_q;
  logic [WIDTH-1:0] data_d;

  // With the enable low, feed the stored value back so the register holds.
  always_comb begin
    data_d = data_q;
    if (reg_write) begin
      data_d = reg_input;
    end
  end

  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      data_q <= RESET_VALUE;
    end else begin
      data_q <= data_d;
    end
  end

  // Output comes straight from the flops, with no bypass from reg_input.
  assign reg_output = data_q;

endmodule : register_16

// File: tb/tb_register_16.sv
// Directed self-checking bench for register_16: reset behaviour, enabled
// writes, hold, back-to-back capture and reset priority over writes.
module tb_register_16;

  logic        clk;
  logic        resetN;
  logic [15:0] regInput;
  logic        regWrite;
  logic [15:0] regOutput;

  int checkCount = 0;
  int errorCount = 0;

  register_16 dut (
    .CLK        (clk),
    .reset      (resetN),
    .reg_input  (regInput),
    .reg_write  (regWrite),
    .reg_output (regOutput)
  );

  // Free-running 10-time-unit clock, low at time zero.
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance one rising edge and settle so outputs are sampled away from the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reset is asserted before any clock edge, then released with writes disabled.
  task automatic test_reset();
    resetN   = 1'b0;
    regWrite = 1'b0;
    regInput = 16'hC3C3;
    #1;
    checkCount++;
    if (regOutput !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reset_before_edge: got %h expected %h", regOutput, 16'h0000);
    end
    tick();
    checkCount++;
    if (regOutput !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL reset_held_edge: got %h expected %h", regOutput, 16'h0000);
    end
    #2;
    resetN = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checkCount++;
      if (regOutput !== 16'h0000) begin
        errorCount++;
        $display("[TB] FAIL reset_release_hold[%0d]: got %h expected %h", i, regOutput, 16'h0000);
      end
    end
  endtask

  // A single enabled write, then the same input held with the enable still high.
  task automatic test_write_hold();
    regInput = 16'h8888;
    regWrite = 1'b1;
    tick();
    checkCount++;
    if (regOutput !== 16'h8888) begin
      errorCount++;
      $display("[TB] FAIL write_8888: got %h expected %h", regOutput, 16'h8888);
    end
    for (int i = 0; i < 5; i++) begin
      tick();
      checkCount++;
      if (regOutput !== 16'h8888) begin
        errorCount++;
        $display("[TB] FAIL write_repeat[%0d]: got %h expected %h", i, regOutput, 16'h8888);
      end
    end
  endtask

  // With the enable low the input must be ignored on every edge.
  task automatic test_write_disable();
    logic [15:0] ignored [4] = '{16'hFFFF, 16'h0000, 16'h5555, 16'hFFFF};
    regWrite = 1'b0;
    for (int i = 0; i < 4; i++) begin
      regInput = ignored[i];
      tick();
      checkCount++;
      if (regOutput !== 16'h8888) begin
        errorCount++;
        $display("[TB] FAIL disabled_hold[%0d]: got %h expected %h", i, regOutput, 16'h8888);
      end
    end
  endtask

  // Consecutive edges each capture the input presented just before them.
  task automatic test_back_to_back();
    logic [15:0] seq [3] = '{16'h1234, 16'hABCD, 16'h0001};
    regWrite = 1'b1;
    for (int i = 0; i < 3; i++) begin
      regInput = seq[i];
      #1;
      checkCount++;
      if (i > 0 && regOutput !== seq[i-1]) begin
        errorCount++;
        $display("[TB] FAIL b2b_no_comb_path[%0d]: got %h expected %h", i, regOutput, seq[i-1]);
      end else if (i == 0 && regOutput !== 16'h8888) begin
        errorCount++;
        $display("[TB] FAIL b2b_no_comb_path[%0d]: got %h expected %h", i, regOutput, 16'h8888);
      end
      tick();
      checkCount++;
      if (regOutput !== seq[i]) begin
        errorCount++;
        $display("[TB] FAIL b2b_capture[%0d]: got %h expected %h", i, regOutput, seq[i]);
      end
    end
    regWrite = 1'b0;
    tick();
    checkCount++;
    if (regOutput !== 16'h0001) begin
      errorCount++;
      $display("[TB] FAIL b2b_final_hold: got %h expected %h", regOutput, 16'h0001);
    end
  endtask

  // Reset pulsed between edges clears immediately; the next write still works.
  task automatic test_async_reset();
    regInput = 16'h5A5A;
    regWrite = 1'b1;
    tick();
    checkCount++;
    if (regOutput !== 16'h5A5A) begin
      errorCount++;
      $display("[TB] FAIL store_5a5a: got %h expected %h", regOutput, 16'h5A5A);
    end
    regWrite = 1'b0;
    #2;
    resetN = 1'b0;
    #1;
    checkCount++;
    if (regOutput !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL async_clear: got %h expected %h", regOutput, 16'h0000);
    end
    resetN = 1'b1;
    #1;
    checkCount++;
    if (regOutput !== 16'h0000) begin
      errorCount++;
      $display("[TB] FAIL async_release_no_edge: got %h expected %h", regOutput, 16'h0000);
    end
    regInput = 16'hFFFF;
    regWrite = 1'b1;
    tick();
    checkCount++;
    if (regOutput !== 16'hFFFF) begin
      errorCount++;
      $display("[TB] FAIL write_after_reset: got %h expected %h", regOutput, 16'hFFFF);
    end
  endtask

  // Reset held low wins over an enabled write on every edge.
  task automatic test_reset_overrides_write();
    #2;
    resetN   = 1'b0;
    regWrite = 1'b1;
    regInput = 16'h7777;
    for (int i = 0; i < 3; i++) begin
      tick();
      checkCount++;
      if (regOutput !== 16'h0000) begin
        errorCount++;
        $display("[TB] FAIL reset_priority[%0d]: got %h expected %h", i, regOutput, 16'h0000);
      end
    end
    #2;
    resetN = 1'b1;
    tick();
    checkCount++;
    if (regOutput !== 16'h7777) begin
      errorCount++;
      $display("[TB] FAIL first_edge_after_release: got %h expected %h", regOutput, 16'h7777);
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    test_reset();
    test_write_hold();
    test_write_disable();
    test_back_to_back();
    test_async_reset();
    test_reset_overrides_write();
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule : tb_register_16
